iiitb_sd_serializer: RTL and testbench
======================================

// Module: iiitb_sd_serializer
// PURPOSE
//   Upstream feeder for the sequence-detector stage.
//   Accepts WIDTH-bit parallel words on a valid/ready handshake and shifts them out one bit per clock.
//   ser_out drives the detector's din input directly.
//   A one-word holding register plus the shift register allow gap-free back-to-back words.
//   An optional idle gap can be inserted between words.
// PARAMETERS
//   WIDTH      8   payload bits per word; legal range 2..32
//   MSB_FIRST  1   1: s_data[WIDTH-1] is sent first; 0: s_data[0] is sent first
//   IDLE_BIT   0   value driven on ser_out whenever ser_valid=0
//   GAP        0   idle cycles inserted after each word; legal range 0..255
// PORTS
//   clk        in   1      rising-edge clock
//   reset      in   1      asynchronous, active-low reset
//   s_data     in   WIDTH  parallel word, sampled only on handshake
//   s_valid    in   1      upstream word available
//   s_ready    out  1      holding register can accept a word
//   ser_out    out  1      serial bit stream to detector din
//   ser_valid  out  1      ser_out carries a payload bit this cycle
//   word_done  out  1      1-cycle pulse, coincident with the last bit of each word
//   busy       out  1      a word is being shifted, in GAP, or held
// BEHAVIOUR
//   Reset (reset=0, asynchronous), all forced immediately:
//     - state=IDLE; holding register empty; bit counter=0
//     - ser_out=IDLE_BIT; ser_valid=0; word_done=0; busy=0
//     - s_ready=0 while reset is low; s_ready=1 from the first cycle after release
//     - an in-flight word is discarded with no partial bits emitted afterwards
//   Handshake:
//     - Transfer occurs on the clk edge where s_valid=1 and s_ready=1.
//     - s_ready = ~hold_full, gated low during reset.
//     - s_data is captured into the holding register on that edge only.
//   Outputs: ser_out, ser_valid and word_done are registered.
//   State machine IDLE / SHIFT / GAPW:
//     - IDLE, hold_full=1 at an edge:
//         launch first bit (ser_valid=1); load remaining bits into the shift register; cnt=1;
//         empty the holding register; go to SHIFT.
//     - IDLE, hold empty: ser_out=IDLE_BIT, ser_valid=0.
//     - SHIFT, cnt<WIDTH: launch next bit; cnt+1.
//         When the launched bit is bit WIDTH-1 of the word, word_done=1 in that same cycle.
//     - After the last bit, GAP>0: go to GAPW for exactly GAP cycles.
//         ser_out=IDLE_BIT, ser_valid=0 throughout; then behave as IDLE.
//     - After the last bit, GAP=0 and hold_full=1: the next edge launches the next word's first bit.
//         No bubble between words.
//     - After the last bit, GAP=0 and hold empty: go to IDLE.
//   Latency: handshake at edge E0 -> first bit valid after edge E1 (state IDLE, hold previously empty).
//   Holding register refills during SHIFT/GAPW.
//     - s_ready reasserts the cycle after hold is loaded into the shifter.
//     - Load and a new accept may occur on the same edge; the new word is kept and the old one moved.
//   Arithmetic:
//     - cnt is $clog2(WIDTH+1) bits; no wrap inside a word.
//     - GAP counter is 8 bits.
//   busy = (state!=IDLE) | hold_full.
// TESTING
//   1) Reset, MSB_FIRST=1, GAP=0, send 8'h90 at E0
//      -> ser_out 1,0,0,1,0,0,0,0 after E1..E8, ser_valid=1 throughout;
//         word_done only after E8; detector dout pulses once.
//   2) s_valid held, words 8'h91 then 8'h2C
//      -> 16 consecutive ser_valid=1 cycles, no bubble;
//         s_ready low while hold full; exactly 2 word_done pulses.
//   3) MSB_FIRST=0, send 8'h09 -> ser_out 1,0,0,1,0,0,0,0.
//   4) GAP=2, two words 8'hFF
//      -> 8 valid bits, then exactly 2 cycles ser_valid=0 with ser_out=IDLE_BIT, then 8 valid bits.
//   5) reset low after 3 bits of 8'hA5
//      -> ser_valid=0, ser_out=IDLE_BIT, busy=0, s_ready=0 immediately;
//         after release s_ready=1 and no leftover bits.
//   6) hold full, s_valid=1, s_data toggling -> no capture until s_ready=1;
//      the word sent is the value present on the accepting edge.

Source files
------------

// File: rtl/iiitb_sd_serializer_if.sv
// Parallel-word valid/ready handshake between the upstream source and the serializer.
`timescale 1ns/1ps
interface iiitb_sd_serializer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] s_data;
  logic             s_valid;
  logic             s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/iiitb_sd_serializer.sv
// Parallel-to-serial feeder for the sequence detector: one holding word plus a shifter,
// optional idle gap between words.
//
//   state | meaning
//   IDLE  | no word in flight; launches the held word on the next edge if one is waiting
//   SHIFT | word in flight; cnt = bits already launched
//   GAPW  | idle gap after a word; gap_cnt counts down to zero
`timescale 1ns/1ps
module iiitb_sd_serializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0,
  parameter int GAP       = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  iiitb_sd_serializer_if.slave s,
  output logic                 ser_out,
  output logic                 ser_valid,
  output logic                 word_done,
  output logic                 busy
);
  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_PENULT = CW'(WIDTH - 1);
  localparam bit            HAS_GAP    = (GAP > 0);
  localparam logic [7:0]    GAP_LOAD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAPW  = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [7:0]       gap_cnt, gap_n;
  logic [WIDTH-1:0] sh, sh_n;
  logic [WIDTH-1:0] hold, hold_n;
  logic             hold_full, full_n;
  logic             out_n, vld_n, done_n;
  logic             accept;
  logic             word_slot;

  function automatic logic head(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] v);
    return MSB_FIRST ? (v << 1) : (v >> 1);
  endfunction

  assign s.s_ready = reset & ~hold_full;
  assign accept    = s.s_valid & s.s_ready;
  assign busy      = (state != IDLE) | hold_full;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    gap_n     = gap_cnt;
    sh_n      = sh;
    hold_n    = hold;
    full_n    = hold_full;
    out_n     = IDLE_BIT;
    vld_n     = 1'b0;
    done_n    = 1'b0;
    word_slot = 1'b0;

    case (state)
      IDLE: word_slot = 1'b1;
      SHIFT: begin
        if (cnt < CNT_LAST) begin
          out_n  = head(sh);
          sh_n   = advance(sh);
          vld_n  = 1'b1;
          cnt_n  = cnt + 1'b1;
          done_n = (cnt == CNT_PENULT);
        end else if (HAS_GAP) begin
          state_n = GAPW;
          gap_n   = GAP_LOAD;
        end else begin
          word_slot = 1'b1;
        end
      end
      GAPW: begin
        if (gap_cnt != 8'd0) gap_n = gap_cnt - 8'd1;
        else                 word_slot = 1'b1;
      end
      default: state_n = IDLE;
    endcase

    // A word boundary: either start the waiting word back-to-back or fall idle.
    if (word_slot) begin
      if (hold_full) begin
        out_n   = head(hold);
        sh_n    = advance(hold);
        vld_n   = 1'b1;
        cnt_n   = CW'(1);
        full_n  = 1'b0;
        state_n = SHIFT;
      end else begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    end

    if (accept) begin
      hold_n = s.s_data;
      full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      cnt       <= '0;
      gap_cnt   <= '0;
      sh        <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      ser_out   <= IDLE_BIT;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      gap_cnt   <= gap_n;
      sh        <= sh_n;
      hold      <= hold_n;
      hold_full <= full_n;
      ser_out   <= out_n;
      ser_valid <= vld_n;
      word_done <= done_n;
    end
  end
endmodule

// File: tb/tb_iiitb_sd_serializer.sv
// Bench for iiitb_sd_serializer: three configurations (MSB/GAP0, LSB/GAP0, MSB/GAP2)
// checked by fixed vectors, hand sequences and a queue-based stream model.
`timescale 1ns/1ps
module tb_iiitb_sd_serializer;
  localparam int   W  = 8;
  localparam logic IB = 1'b0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iiitb_sd_serializer_if #(.WIDTH(W)) bus_a (), bus_b (), bus_c ();
  logic [2:0] ser_out, ser_valid, word_done, busy;

  iiitb_sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IB), .GAP(0)) u_a (
    .clk(clk), .reset(rst_n), .s(bus_a), .ser_out(ser_out[0]),
    .ser_valid(ser_valid[0]), .word_done(word_done[0]), .busy(busy[0]));
  iiitb_sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(IB), .GAP(0)) u_b (
    .clk(clk), .reset(rst_n), .s(bus_b), .ser_out(ser_out[1]),
    .ser_valid(ser_valid[1]), .word_done(word_done[1]), .busy(busy[1]));
  iiitb_sd_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(IB), .GAP(2)) u_c (
    .clk(clk), .reset(rst_n), .s(bus_c), .ser_out(ser_out[2]),
    .ser_valid(ser_valid[2]), .word_done(word_done[2]), .busy(busy[2]));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Stream model: accepted words queue up; every valid bit must be the next bit of the
  // oldest word, word_done on its last bit, and gaps between words bounded by GAP.
  logic [7:0] expq[3][$];
  logic [7:0] cur[3];
  int         bitk[3], gapn[3];
  bit         ingap[3], exact[3];

  function automatic bit msb_of(input int id);
    return id != 1;
  endfunction
  function automatic int gap_of(input int id);
    return (id == 2) ? 2 : 0;
  endfunction

  task automatic mon(input int id, input logic sv, input logic so, input logic wd,
                     input logic acc, input logic [7:0] d);
    logic eb;
    if (sv) begin
      if (bitk[id] == 0) begin
        check($sformatf("word_available[%0d]", id), 32'(expq[id].size() != 0), 1);
        cur[id] = (expq[id].size() != 0) ? expq[id].pop_front() : 8'h00;
        if (ingap[id]) begin
          if (exact[id]) check($sformatf("gap_exact[%0d]", id), gapn[id], gap_of(id));
          else           check($sformatf("gap_min[%0d]", id), 32'(gapn[id] >= gap_of(id)), 1);
        end
        ingap[id] = 1'b0;
      end
      eb = msb_of(id) ? cur[id][7-bitk[id]] : cur[id][bitk[id]];
      check($sformatf("ser_bit[%0d]", id), so, eb);
      check($sformatf("word_done[%0d]", id), wd, 32'(bitk[id] == 7));
      bitk[id]++;
      if (bitk[id] == 8) begin
        bitk[id]  = 0;
        ingap[id] = 1'b1;
        gapn[id]  = 0;
        exact[id] = (expq[id].size() != 0);
      end
    end else begin
      check($sformatf("idle_out[%0d]", id), so, IB);
      check($sformatf("idle_done[%0d]", id), wd, 0);
      if (ingap[id]) gapn[id]++;
    end
    if (acc) expq[id].push_back(d);
  endtask

  logic [63:0] a_bits, c_pat;
  int          a_n, a_done, a_run, a_maxrun;

  always @(negedge clk) begin
    c_pat = {c_pat[62:0], ser_valid[2]};
    if (!rst_n) begin
      for (int id = 0; id < 3; id++) begin
        expq[id].delete();
        bitk[id]  = 0;
        gapn[id]  = 0;
        ingap[id] = 1'b0;
        exact[id] = 1'b0;
      end
    end else begin
      mon(0, ser_valid[0], ser_out[0], word_done[0], bus_a.s_valid & bus_a.s_ready, bus_a.s_data);
      mon(1, ser_valid[1], ser_out[1], word_done[1], bus_b.s_valid & bus_b.s_ready, bus_b.s_data);
      mon(2, ser_valid[2], ser_out[2], word_done[2], bus_c.s_valid & bus_c.s_ready, bus_c.s_data);
      if (ser_valid[0]) begin
        a_bits = {a_bits[62:0], ser_out[0]};
        a_n++;
        a_run++;
        if (a_run > a_maxrun) a_maxrun = a_run;
      end else begin
        a_run = 0;
      end
      if (word_done[0]) a_done++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_a();
    a_bits = '0; a_n = 0; a_done = 0; a_run = 0; a_maxrun = 0;
  endtask

  typedef struct {
    logic [7:0] word;
    logic [7:0] seq_msb;
    logic [7:0] seq_lsb;
  } vec_t;
  vec_t tbl[6];

  logic [7:0] sa, sb, sc, va, vb, vc, da;
  logic [7:0] accw[3];
  int         nacc, stalls;

  initial begin
    // serial sequences written first-sent bit leftmost
    tbl[0] = '{8'h90, 8'h90, 8'h09};
    tbl[1] = '{8'h09, 8'h09, 8'h90};
    tbl[2] = '{8'h01, 8'h01, 8'h80};
    tbl[3] = '{8'hC8, 8'hC8, 8'h13};
    tbl[4] = '{8'hFF, 8'hFF, 8'hFF};
    tbl[5] = '{8'hA5, 8'hA5, 8'hA5};

    bus_a.s_valid = 0; bus_b.s_valid = 0; bus_c.s_valid = 0;
    bus_a.s_data = '0; bus_b.s_data = '0; bus_c.s_data = '0;
    clear_a();
    c_pat = '0;

    // reset state
    step(); step();
    check("rst_ser_valid", ser_valid, 3'b000);
    check("rst_ser_out", ser_out, {3{IB}});
    check("rst_word_done", word_done, 3'b000);
    check("rst_busy", busy, 3'b000);
    check("rst_ready", {bus_a.s_ready, bus_b.s_ready, bus_c.s_ready}, 3'b000);
    rst_n = 1'b1;
    step();
    check("ready_after_rst", {bus_a.s_ready, bus_b.s_ready, bus_c.s_ready}, 3'b111);

    // single-word vectors on all three configurations
    for (int i = 0; i < 6; i++) begin
      bus_a.s_data = tbl[i].word; bus_b.s_data = tbl[i].word; bus_c.s_data = tbl[i].word;
      bus_a.s_valid = 1; bus_b.s_valid = 1; bus_c.s_valid = 1;
      step();
      bus_a.s_valid = 0; bus_b.s_valid = 0; bus_c.s_valid = 0;
      check("hold_busy", busy[0], 1);
      check("hold_ready_low", bus_a.s_ready, 0);
      for (int k = 0; k < 8; k++) begin
        step();
        sa = {sa[6:0], ser_out[0]}; sb = {sb[6:0], ser_out[1]}; sc = {sc[6:0], ser_out[2]};
        va = {va[6:0], ser_valid[0]}; vb = {vb[6:0], ser_valid[1]}; vc = {vc[6:0], ser_valid[2]};
        da = {da[6:0], word_done[0]};
      end
      check($sformatf("vec%0d_msb", i), sa, tbl[i].seq_msb);
      check($sformatf("vec%0d_lsb", i), sb, tbl[i].seq_lsb);
      check($sformatf("vec%0d_gap_cfg", i), sc, tbl[i].seq_msb);
      check($sformatf("vec%0d_valid", i), {va, vb, vc}, 24'hFFFFFF);
      check($sformatf("vec%0d_done", i), da, 8'h01);
      step(); step(); step(); step();
      check($sformatf("vec%0d_idle", i), {ser_valid, busy}, 6'b0);
    end

    // back-to-back words with s_valid held
    clear_a();
    bus_a.s_data = 8'h91; bus_a.s_valid = 1;
    step();
    check("b2b_ready_full", bus_a.s_ready, 0);
    bus_a.s_data = 8'h2C;
    step();
    check("b2b_ready_reopen", bus_a.s_ready, 1);
    step();
    bus_a.s_valid = 0;
    check("b2b_ready_full2", bus_a.s_ready, 0);
    for (int i = 0; i < 22; i++) step();
    check("b2b_nbits", a_n, 16);
    check("b2b_run", a_maxrun, 16);
    check("b2b_done", a_done, 2);
    check("b2b_bits", a_bits[15:0], 16'h912C);

    // GAP=2 configuration, two 8'hFF words
    bus_c.s_data = 8'hFF; bus_c.s_valid = 1;
    step();
    step();
    c_pat = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (i == 0) bus_c.s_valid = 0;
    end
    check("gap_pattern", c_pat[19:0], 20'hFF3FC);

    // reset in the middle of a word
    bus_a.s_data = 8'hA5; bus_a.s_valid = 1;
    step();
    bus_a.s_valid = 0;
    step(); step(); step();
    check("mid_valid_before", ser_valid[0], 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_valid", ser_valid[0], 0);
    check("mid_rst_out", ser_out[0], IB);
    check("mid_rst_busy", busy[0], 0);
    check("mid_rst_ready", bus_a.s_ready, 0);
    step();
    rst_n = 1'b1;
    #1;
    check("mid_rel_ready", bus_a.s_ready, 1);
    clear_a();
    for (int i = 0; i < 12; i++) step();
    check("mid_leftover", a_n, 0);

    // toggling data while the holding register is full
    clear_a();
    nacc = 0; stalls = 0;
    bus_a.s_valid = 1;
    for (int c = 0; c < 60 && nacc < 3; c++) begin
      bus_a.s_data = 8'($urandom);
      if (bus_a.s_ready) begin
        accw[nacc] = bus_a.s_data;
        nacc++;
      end else begin
        stalls++;
      end
      step();
    end
    bus_a.s_valid = 0;
    check("tog_accepted", nacc, 3);
    check("tog_stalled", 32'(stalls > 0), 1);
    for (int i = 0; i < 30; i++) step();
    check("tog_nbits", a_n, 24);
    check("tog_bits", a_bits[23:0], {accw[0], accw[1], accw[2]});

    // randomized traffic against the stream model
    for (int i = 0; i < 800; i++) begin
      bus_a.s_valid = ($urandom_range(0, 3) != 0); bus_a.s_data = 8'($urandom);
      bus_b.s_valid = ($urandom_range(0, 1) != 0); bus_b.s_data = 8'($urandom);
      bus_c.s_valid = ($urandom_range(0, 4) == 0); bus_c.s_data = 8'($urandom);
      step();
    end
    bus_a.s_valid = 0; bus_b.s_valid = 0; bus_c.s_valid = 0;
    for (int i = 0; i < 60; i++) step();
    for (int id = 0; id < 3; id++) begin
      check($sformatf("drain_queue[%0d]", id), expq[id].size(), 0);
      check($sformatf("drain_bit[%0d]", id), bitk[id], 0);
    end
    check("drain_busy", busy, 3'b000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
